// File: rtl/hub_router_pkg.sv
// Shared types and helpers for the hub message router: destination decode
// and classification of the FPGA-ID field carried in every message.
package hub_router_pkg;

    localparam int unsigned BROADCAST_ID = 0;

    // Upper bounds for the generic helpers below; router parameters must fit.
    localparam int unsigned MSG_MAX_W = 512;
    localparam int unsigned ID_MAX_W  = 8;

    typedef logic [ID_MAX_W-1:0] fpga_id_t;

    typedef enum logic [1:0] {
        DEST_BCAST   = 2'd0,
        DEST_UNICAST = 2'd1,
        DEST_INVALID = 2'd2
    } dest_kind_e;

    // FPGA-ID field: the top id_w bits of a msg_w-bit message.
    function automatic fpga_id_t dest_of(input logic [MSG_MAX_W-1:0] msg,
                                         input int unsigned         msg_w,
                                         input int unsigned         id_w);
        fpga_id_t mask;
        mask = fpga_id_t'((32'd1 << id_w) - 32'd1);
        return fpga_id_t'(msg >> (msg_w - id_w)) & mask;
    endfunction

    // Leaf port p carries FPGA ID p+1.
    function automatic fpga_id_t port_of(input fpga_id_t id);
        return id - fpga_id_t'(1);
    endfunction

    function automatic dest_kind_e classify(input fpga_id_t    id,
                                            input int unsigned leaf_count);
        if (id == fpga_id_t'(BROADCAST_ID))
            return DEST_BCAST;
        else if (32'(id) <= leaf_count)
            return DEST_UNICAST;
        else
            return DEST_INVALID;
    endfunction

endpackage

// File: rtl/hub_output_queue.sv
// One per-destination FIFO. Push is ignored when full (the arbiter never
// grants into a full queue); pop happens whenever the head is valid and the
// leaf is ready. Storage has no reset: count governs validity.
module hub_output_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop_ready,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push & ~full;
    assign do_pop    = pop_ready & ~empty;

    // Next storage, pointers and occupancy; push and pop may coincide.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Control state, cleared asynchronously so a reset drops all entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Message storage.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/hub_message_router.sv
// Hub-side message router: decodes each leaf's destination, grants one
// eligible leaf per cycle round-robin, fans broadcasts out to every other
// leaf's queue, and counts (then drops) messages with an unknown destination.
module hub_message_router
    import hub_router_pkg::*;
#(
    parameter int unsigned LEAF_COUNT     = 2,
    parameter int unsigned HUB_FIFO_WIDTH = 32,
    parameter int unsigned FPGAID_WIDTH   = 2,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [HUB_FIFO_WIDTH*LEAF_COUNT-1:0] leaf_out_data,
    input  logic [LEAF_COUNT-1:0]                leaf_out_valid,
    output logic [LEAF_COUNT-1:0]                leaf_out_ready,
    output logic [HUB_FIFO_WIDTH*LEAF_COUNT-1:0] leaf_in_data,
    output logic [LEAF_COUNT-1:0]                leaf_in_valid,
    input  logic [LEAF_COUNT-1:0]                leaf_in_ready,
    output logic                                 has_message_flying,
    output logic [7:0]                           error_count
);

    localparam int unsigned RR_W  = (LEAF_COUNT > 1) ? $clog2(LEAF_COUNT) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [LEAF_COUNT-1:0][HUB_FIFO_WIDTH-1:0] src_msg;
    fpga_id_t                                  src_dest [LEAF_COUNT];
    dest_kind_e                                src_kind [LEAF_COUNT];

    logic [LEAF_COUNT-1:0]             elig;
    logic                              blocked;
    logic                              grant_vld;
    logic [RR_W-1:0]                   grant_idx;
    int unsigned                       arb_idx;
    logic [RR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [7:0]                        error_count_q, error_count_d;

    logic [LEAF_COUNT-1:0]             q_push;
    logic [HUB_FIFO_WIDTH-1:0]         push_data;
    logic [LEAF_COUNT-1:0]             q_full;
    logic [LEAF_COUNT-1:0]             q_empty;
    logic [LEAF_COUNT-1:0][CNT_W-1:0]  q_count;

    // Split the flat input bus and classify each leaf's destination.
    always_comb begin
        for (int unsigned i = 0; i < LEAF_COUNT; i++) begin
            src_msg[i]  = leaf_out_data[i*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH];
            src_dest[i] = dest_of(MSG_MAX_W'(src_msg[i]), HUB_FIFO_WIDTH, FPGAID_WIDTH);
            src_kind[i] = classify(src_dest[i], LEAF_COUNT);
        end
    end

    // A leaf is eligible when every queue it would write has room; full is
    // the pre-pop state, so a full queue blocks even while it drains.
    always_comb begin
        elig    = '0;
        blocked = 1'b0;
        for (int unsigned i = 0; i < LEAF_COUNT; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < LEAF_COUNT; j++) begin
                case (src_kind[i])
                    DEST_UNICAST: if (32'(port_of(src_dest[i])) == j) blocked = blocked | q_full[j];
                    DEST_BCAST:   if (j != i) blocked = blocked | q_full[j];
                    default:      ;
                endcase
            end
            elig[i] = leaf_out_valid[i] & ~blocked;
        end
    end

    // Round-robin pick starting at rr_ptr; no grant at all while in reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < LEAF_COUNT; k++) begin
            arb_idx = (32'(rr_ptr_q) + k) % LEAF_COUNT;
            if (!grant_vld && elig[arb_idx]) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(arb_idx);
            end
        end
        grant_vld      = grant_vld & reset;
        leaf_out_ready = '0;
        if (grant_vld)
            leaf_out_ready[grant_idx] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (grant_vld)
            rr_ptr_d = (grant_idx == RR_W'(LEAF_COUNT - 1)) ? '0 : grant_idx + RR_W'(1);
    end

    // Route the granted message: one queue, all-but-sender, or the error counter.
    always_comb begin
        push_data     = src_msg[grant_idx];
        q_push        = '0;
        error_count_d = error_count_q;
        if (grant_vld) begin
            case (src_kind[grant_idx])
                DEST_UNICAST:
                    for (int unsigned j = 0; j < LEAF_COUNT; j++)
                        q_push[j] = (32'(port_of(src_dest[grant_idx])) == j);
                DEST_BCAST:
                    for (int unsigned j = 0; j < LEAF_COUNT; j++)
                        q_push[j] = (RR_W'(j) != grant_idx);
                default:
                    if (error_count_q != 8'hFF)
                        error_count_d = error_count_q + 8'd1;
            endcase
        end
    end

    // Arbiter pointer and saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            error_count_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            error_count_q <= error_count_d;
        end
    end

    for (genvar p = 0; p < LEAF_COUNT; p++) begin : g_queue
        hub_output_queue #(
            .WIDTH (HUB_FIFO_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_queue (
            .clk       (clk),
            .reset     (reset),
            .push      (q_push[p]),
            .push_data (push_data),
            .pop_ready (leaf_in_ready[p]),
            .head_data (leaf_in_data[p*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH]),
            .count     (q_count[p]),
            .full      (q_full[p]),
            .empty     (q_empty[p])
        );
        assign leaf_in_valid[p] = (q_count[p] != '0);
    end

    assign has_message_flying = (~&q_empty) | (|leaf_out_valid);
    assign error_count        = error_count_q;

endmodule

// File: tb/tb_hub_message_router.sv
// Bench for hub_message_router with 3 leaves and a 3-bit FPGA-ID field
// (IDs 4..7 invalid). Every cycle is checked against a queue-based model of
// the routing rules; directed steps add explicit checks for the key cases.
module tb_hub_message_router;

    localparam int L   = 3;
    localparam int W   = 32;
    localparam int IDW = 3;
    localparam int D   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [W*L-1:0]   leaf_out_data;
    logic [L-1:0]     leaf_out_valid;
    logic [L-1:0]     leaf_out_ready;
    logic [W*L-1:0]   leaf_in_data;
    logic [L-1:0]     leaf_in_valid;
    logic [L-1:0]     leaf_in_ready;
    logic             has_message_flying;
    logic [7:0]       error_count;

    int total = 0;
    int bad   = 0;

    // stimulus state: each source holds its message until accepted
    logic [W-1:0] src_m [L];
    logic [L-1:0] src_v;
    logic [L-1:0] rdy;

    // reference model
    logic [W-1:0] mq [L][$];
    int           rr  = 0;
    int           err = 0;
    int           last_g;
    logic [L-1:0] obs_iv;
    logic [W*L-1:0] obs_data;
    logic [W-1:0] dq0 [$];

    always #5 clk = ~clk;

    hub_message_router #(
        .LEAF_COUNT     (L),
        .HUB_FIFO_WIDTH (W),
        .FPGAID_WIDTH   (IDW),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .leaf_out_data      (leaf_out_data),
        .leaf_out_valid     (leaf_out_valid),
        .leaf_out_ready     (leaf_out_ready),
        .leaf_in_data       (leaf_in_data),
        .leaf_in_valid      (leaf_in_valid),
        .leaf_in_ready      (leaf_in_ready),
        .has_message_flying (has_message_flying),
        .error_count        (error_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dest(input logic [W-1:0] m);
        logic [IDW-1:0] f;
        f = m[W-1 -: IDW];
        return int'(f);
    endfunction

    // One clock: drive at negedge, check just after, advance the model.
    task automatic cycle();
        logic [L-1:0]   exp_iv, exp_rdy;
        logic [W*L-1:0] exp_data;
        logic           fly, el;
        int             g, d, i;
        @(negedge clk);
        for (int p = 0; p < L; p++) leaf_out_data[p*W +: W] = src_m[p];
        leaf_out_valid = src_v;
        leaf_in_ready  = rdy;
        #1;
        exp_iv = '0; exp_data = '0; obs_data = '0; fly = |src_v;
        for (int p = 0; p < L; p++) begin
            if (mq[p].size() != 0) begin
                exp_iv[p] = 1'b1;
                exp_data[p*W +: W] = mq[p][0];
                fly = 1'b1;
            end
            if (leaf_in_valid[p]) obs_data[p*W +: W] = leaf_in_data[p*W +: W];
        end
        obs_iv = leaf_in_valid;
        g = -1;
        for (int k = 0; k < L; k++) begin
            i  = (rr + k) % L;
            d  = dest(src_m[i]);
            el = 1'b0;
            if (src_v[i]) begin
                if (d == 0) begin
                    el = 1'b1;
                    for (int j = 0; j < L; j++)
                        if (j != i && mq[j].size() >= D) el = 1'b0;
                end else if (d <= L) begin
                    el = (mq[d-1].size() < D);
                end else begin
                    el = 1'b1;
                end
            end
            if (el && g < 0) g = i;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready",     leaf_out_ready,     exp_rdy);
        chk("in_valid",  leaf_in_valid,      exp_iv);
        chk("in_data",   obs_data,           exp_data);
        chk("flying",    has_message_flying, fly);
        chk("err_count", error_count,        err);
        if (leaf_in_valid[0] && rdy[0]) dq0.push_back(leaf_in_data[W-1:0]);
        for (int p = 0; p < L; p++)
            if (exp_iv[p] && rdy[p]) void'(mq[p].pop_front());
        if (g >= 0) begin
            d = dest(src_m[g]);
            if (d == 0) begin
                for (int j = 0; j < L; j++) if (j != g) mq[j].push_back(src_m[g]);
            end else if (d <= L) begin
                mq[d-1].push_back(src_m[g]);
            end else if (err < 255) begin
                err++;
            end
            rr = (g + 1) % L;
            src_v[g] = 1'b0;
        end
        last_g = g;
    endtask

    initial begin
        int   prev, nacc;
        logic [L-1:0] any_iv;

        // reset state, with a leaf already presenting a message
        reset = 1'b0;
        rdy   = '1;
        src_v = '0;
        for (int p = 0; p < L; p++) src_m[p] = '0;
        src_m[0] = 32'h4000_00AA;
        leaf_out_data  = '0;
        leaf_out_data[W-1:0] = src_m[0];
        leaf_out_valid = 3'b001;
        leaf_in_ready  = rdy;
        #3;
        chk("rst_ready",  leaf_out_ready,     3'b000);
        chk("rst_valid",  leaf_in_valid,      3'b000);
        chk("rst_flying", has_message_flying, 1'b1);
        chk("rst_err",    error_count,        8'd0);
        leaf_out_valid = '0;
        #1;
        chk("rst_idle_flying", has_message_flying, 1'b0);
        @(negedge clk); #2 reset = 1'b1;

        // unicast port 0 -> FPGA 2 (port 1)
        src_v[0] = 1'b1; src_m[0] = 32'h4000_00AA;
        cycle();
        chk("uni_grant", last_g, 0);
        cycle();
        chk("uni_iv",   obs_iv,          3'b010);
        chk("uni_data", obs_data[2*W-1 -: W], 32'h4000_00AA);

        // broadcast from port 1
        src_v[1] = 1'b1; src_m[1] = 32'h0000_00BB;
        cycle();
        cycle();
        chk("bc_iv",    obs_iv,               3'b101);
        chk("bc_data0", obs_data[W-1:0],      32'h0000_00BB);
        chk("bc_data2", obs_data[3*W-1 -: W], 32'h0000_00BB);
        cycle();
        chk("bc_once",  obs_iv,               3'b000);

        // fairness: ports 0 and 1 both stream to FPGA 1
        src_v[0] = 1'b1; src_m[0] = 32'h2000_0100;
        src_v[1] = 1'b1; src_m[1] = 32'h2000_0200;
        prev = -1;
        for (int n = 0; n < 8; n++) begin
            cycle();
            chk("fair_alt", ((last_g == 0 || last_g == 1) && last_g != prev), 1'b1);
            prev = last_g;
            if (last_g >= 0) begin
                src_v[last_g] = 1'b1;
                src_m[last_g] = 32'h2000_0000 | W'((last_g + 1) * 256 + n + 1);
            end
        end
        src_v = '0;
        cycle(); cycle();

        // backpressure: fill queue 0, fifth message must wait for a pop
        rdy[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            src_v[2] = 1'b1; src_m[2] = 32'h2000_0010 + W'(n);
            cycle();
            chk("bp_acc", last_g, 2);
        end
        src_v[2] = 1'b1; src_m[2] = 32'h2000_0014;
        cycle();
        chk("bp_full", leaf_out_ready, 3'b000);
        cycle();
        chk("bp_full2", leaf_out_ready, 3'b000);
        dq0.delete();
        rdy[0] = 1'b1;
        cycle();
        chk("bp_popcyc", leaf_out_ready, 3'b000);
        cycle();
        chk("bp_retry", last_g, 2);
        for (int n = 0; n < 6; n++) cycle();
        chk("bp_count", dq0.size(), 5);
        for (int k = 0; k < 5 && k < dq0.size(); k++)
            chk("bp_order", dq0[k], 32'h2000_0010 + W'(k));

        // invalid destination, 300 messages
        nacc = 0; any_iv = '0;
        for (int n = 0; n < 300; n++) begin
            src_v[0] = 1'b1; src_m[0] = 32'hA000_0000 | W'(n);
            cycle();
            if (last_g == 0) nacc++;
            any_iv |= obs_iv;
        end
        cycle();
        chk("inv_acc",   nacc,        300);
        chk("inv_noout", any_iv,      3'b000);
        chk("inv_err",   error_count, 8'd255);

        // asynchronous reset with three entries buffered in queue 1
        rdy[1] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            src_v[0] = 1'b1; src_m[0] = 32'h4000_0300 + W'(n);
            cycle();
        end
        cycle();
        chk("pre_rst_iv", obs_iv, 3'b010);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_iv",     leaf_in_valid,      3'b000);
        chk("mid_rst_err",    error_count,        8'd0);
        chk("mid_rst_flying", has_message_flying, 1'b0);
        chk("mid_rst_ready",  leaf_out_ready,     3'b000);
        for (int p = 0; p < L; p++) mq[p].delete();
        rr = 0; err = 0;
        @(negedge clk); #2 reset = 1'b1;
        rdy = '1;

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < L; p++) begin
                rdy[p] = ($urandom_range(0, 3) != 0);
                if (!src_v[p] && $urandom_range(0, 1) == 1) begin
                    src_v[p] = 1'b1;
                    src_m[p] = {3'($urandom_range(0, 4)), 29'($urandom)};
                end
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
